sbox_pow5: RTL
==============

SBOX_POW5 -- requirements
Module: sbox_pow5

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 255, field element width.
REQ-002 SHALL have parameter MUL_LATENCY_HINT, default 3; documentation only, no RTL effect.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port in_valid_i  input  1  input element valid.
REQ-006 SHALL have port in_ready_o  output  1  block accepts an input element.
REQ-007 SHALL have port in_data_i  input  DATA_WIDTH  element x, Montgomery form.
REQ-008 SHALL have port in_bypass_i  input  1  pass x unchanged (partial-round lanes).
REQ-009 SHALL have port mul_valid_o  output  1  multiplier request valid.
REQ-010 SHALL have port mul_ready_i  input  1  multiplier accepts request.
REQ-011 SHALL have ports mul_op1_o and mul_op2_o  output  DATA_WIDTH each  multiplier operands.
REQ-012 SHALL have port mul_res_valid_i  input  1  multiplier result valid.
REQ-013 SHALL have port mul_res_ready_o  output  1  block accepts multiplier result.
REQ-014 SHALL have port mul_res_i  input  DATA_WIDTH  Montgomery product.
REQ-015 SHALL have port out_valid_o  output  1  result valid.
REQ-016 SHALL have port out_ready_i  input  1  downstream accepts result.
REQ-017 SHALL have port out_data_o  output  DATA_WIDTH  x^5 in Montgomery form, or x when bypassed.

Function
REQ-018 SHALL use FSM states IDLE, SQ1_REQ, SQ1_WAIT, SQ2_REQ, SQ2_WAIT, MUL_REQ, MUL_WAIT, DONE.
REQ-019 SHALL assert in_ready_o in IDLE, and in DONE only when out_ready_i is high in the same cycle.
REQ-020 SHALL, on input handshake, latch x and go to DONE if in_bypass_i is set, else to SQ1_REQ.
REQ-021 SHALL drive mul_valid_o only in *_REQ states, with operands (x,x), (x2,x2) and (x4,x) respectively.
REQ-022 SHALL hold mul_valid_o and both operands stable until mul_ready_i; on handshake, go *_REQ -> *_WAIT.
REQ-023 SHALL assert mul_res_ready_o only in *_WAIT states; unsolicited results in other states SHALL be ignored.
REQ-024 SHALL, on result handshake, capture x2 and go to SQ2_REQ, capture x4 and go to MUL_REQ, or capture x5 and go to DONE.
REQ-025 SHALL assert out_valid_o exactly in DONE and hold out_data_o stable until out_ready_i.
REQ-026 SHALL, on output handshake in DONE, go to the next state per REQ-020 if a simultaneous input handshake occurs, else to IDLE (back-to-back, no bubble).
REQ-027 SHALL, with mul_ready_i=1 and result L cycles after request, raise out_valid_o 3L+4 cycles after input handshake (13 for L=3); bypass latency SHALL be 1 cycle.
REQ-028 SHALL perform no arithmetic itself; all field operations go through the multiplier port.

Reset
REQ-029 SHALL set state IDLE, out_valid_o=0, mul_valid_o=0, mul_res_ready_o=0, in_ready_o=1 (after reset), and all data registers to 0 on reset.
REQ-030 SHALL abandon any in-flight element when rst asserts mid-operation; the multiplier is reset by the same rst.

Structure
REQ-031 SHALL take DATA_WIDTH, MODULUS and the FSM state encoding from the shared Poseidon field package.
REQ-032 SHALL contain no sub-module; the multiplier is external, connected at the parent level.

Verification
REQ-033 Bench multiplier model: res = op1*op2 mod MODULUS, L=3, ready always high. Input x=2 -> out 32 after 13 cycles.
REQ-034 Inputs x=MODULUS-1 then x=3 back-to-back, out_ready_i=1 -> outs MODULUS-1 then 243; no idle cycle between jobs.
REQ-035 x=5 with in_bypass_i=1 -> out 5 one cycle after handshake; mul_valid_o never asserted.
REQ-036 mul_ready_i random 50%, out_ready_i low 7 cycles -> operands and out_data_o stable while stalled; x=7 -> 16807.
REQ-037 rst pulsed during SQ2_WAIT -> all outputs at reset values next cycle; a following x=2 -> 32.
REQ-038 Spurious mul_res_valid_i in IDLE -> mul_res_ready_o=0, no state change.

Source files
------------

// File: rtl/sbox_pow5_pkg.sv
// Shared Poseidon field definitions: element width, prime modulus and the
// x^5 S-box sequencer state encoding.
package sbox_pow5_pkg;

  localparam int unsigned FIELD_WIDTH = 255;

  // BN254 scalar field prime
  localparam logic [FIELD_WIDTH-1:0] MODULUS =
    255'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef enum logic [2:0] {
    IDLE,
    SQ1_REQ,
    SQ1_WAIT,
    SQ2_REQ,
    SQ2_WAIT,
    MUL_REQ,
    MUL_WAIT,
    DONE
  } sbox_state_e;

endpackage

// File: rtl/sbox_pow5.sv
// Poseidon S-box x -> x^5 sequenced over an external Montgomery multiplier:
// x2 = x*x, x4 = x2*x2, x5 = x4*x. Bypass lanes return x unchanged.
module sbox_pow5
  import sbox_pow5_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = FIELD_WIDTH,
  parameter int unsigned MUL_LATENCY_HINT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_bypass_i,
  output logic                  mul_valid_o,
  input  logic                  mul_ready_i,
  output logic [DATA_WIDTH-1:0] mul_op1_o,
  output logic [DATA_WIDTH-1:0] mul_op2_o,
  input  logic                  mul_res_valid_i,
  output logic                  mul_res_ready_o,
  input  logic [DATA_WIDTH-1:0] mul_res_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  if (MUL_LATENCY_HINT == 0 || DATA_WIDTH < $bits(MODULUS)) begin : g_bad_cfg
    $error("sbox_pow5: DATA_WIDTH too small for MODULUS or zero latency hint");
  end

  sbox_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] x2_q, x2_d;
  logic [DATA_WIDTH-1:0] x4_q, x4_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  in_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      x2_q    <= '0;
      x4_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      x2_q    <= x2_d;
      x4_q    <= x4_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    x2_d            = x2_q;
    x4_d            = x4_q;
    res_d           = res_q;
    in_ready_o      = 1'b0;
    mul_valid_o     = 1'b0;
    mul_op1_o       = '0;
    mul_op2_o       = '0;
    mul_res_ready_o = 1'b0;
    out_valid_o     = 1'b0;
    in_hs           = 1'b0;

    unique case (state_q)
      IDLE: in_ready_o = 1'b1;
      SQ1_REQ: begin
        mul_valid_o = 1'b1;
        mul_op1_o   = x_q;
        mul_op2_o   = x_q;
        if (mul_ready_i) state_d = SQ1_WAIT;
      end
      SQ1_WAIT: begin
        mul_res_ready_o = 1'b1;
        if (mul_res_valid_i) begin
          x2_d    = mul_res_i;
          state_d = SQ2_REQ;
        end
      end
      SQ2_REQ: begin
        mul_valid_o = 1'b1;
        mul_op1_o   = x2_q;
        mul_op2_o   = x2_q;
        if (mul_ready_i) state_d = SQ2_WAIT;
      end
      SQ2_WAIT: begin
        mul_res_ready_o = 1'b1;
        if (mul_res_valid_i) begin
          x4_d    = mul_res_i;
          state_d = MUL_REQ;
        end
      end
      MUL_REQ: begin
        mul_valid_o = 1'b1;
        mul_op1_o   = x4_q;
        mul_op2_o   = x_q;
        if (mul_ready_i) state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        mul_res_ready_o = 1'b1;
        if (mul_res_valid_i) begin
          res_d   = mul_res_i;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          in_ready_o = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Input acceptance is shared by IDLE and a draining DONE, so it overrides
    // the per-state next state to give back-to-back jobs without a bubble.
    in_hs = in_valid_i && in_ready_o;
    if (in_hs) begin
      x_d = in_data_i;
      if (in_bypass_i) begin
        res_d   = in_data_i;
        state_d = DONE;
      end else begin
        state_d = SQ1_REQ;
      end
    end
  end

  assign out_data_o = res_q;

endmodule
